hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised load-use hazard controller for the 5-stage pipeline. It sits between the IF/ID and ID/EX pipeline registers and drives PC hold, IF/ID hold, ID/EX bubble insertion and IF/ID flush.
- Generalises single-cycle load-use detection with the following:
  - configurable load latency, sustained through a stall FSM;
  - r0 exclusion and per-operand use qualifiers;
  - branch flush;
  - external memory-wait freeze;
  - a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, total bubble cycles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_idrs_i  in  REG_AW  rs field of the instruction in ID.
- if_idrt_i  in  REG_AW  rt field of the instruction in ID.
- id_uses_rs_i  in  1  ID instruction reads rs.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_ex_rd_i  in  REG_AW  destination register of the instruction in EX.
- id_ex_memread_i  in  1  instruction in EX is a load.
- branch_taken_i  in  1  branch/jump in ID resolved taken this cycle.
- mem_busy_i  in  1  data memory not ready; the whole pipeline freezes.
- pc_o  out  1  1 = hold PC.
- if_id_o  out  1  1 = hold IF/ID.
- mux8_o  out  1  1 = zero ID/EX control signals (bubble).
- ex_hold_o  out  1  1 = hold ID/EX and later stages (memory freeze).
- if_id_flush_o  out  1  1 = clear IF/ID to NOP.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_o=1.

Behaviour:
- Reset: synchronous and active-high.
  - While rst_i=1, all outputs are forced to 0 combinationally.
  - On the clock edge with rst_i=1: state←IDLE, remaining←0, stall_cnt_o←0.
  - A reset during STALL abandons the remaining bubbles.
- Hazard term:
  - haz = id_ex_memread_i & (id_ex_rd_i != 0) & ((id_uses_rs_i & if_idrs_i==id_ex_rd_i) | (id_uses_rt_i & if_idrt_i==id_ex_rd_i)).
  - Register 0 never causes a stall.
- FSM state IDLE:
  - pc_o = if_id_o = mux8_o = haz & ~mem_busy_i. Detection is combinational, with 0-cycle latency.
  - If haz & ~mem_busy_i & LOAD_LAT>1: next state STALL, remaining←LOAD_LAT-1.
  - If LOAD_LAT=1, stay in IDLE. This gives the single-bubble behaviour; haz is naturally cleared next cycle because EX then holds the bubble.
- FSM state STALL:
  - pc_o = if_id_o = mux8_o = 1; the haz input is ignored.
  - Each non-frozen cycle: remaining←remaining-1.
  - Leaving: when remaining==1 and ~mem_busy_i, next state IDLE.
  - Total bubble cycles per hazard = LOAD_LAT exactly.
- Memory freeze, any state:
  - mem_busy_i=1 forces ex_hold_o=1, pc_o=1, if_id_o=1, mux8_o=0.
  - The FSM and remaining do not change. The freeze extends the stall without consuming bubble count.
- Flush:
  - if_id_flush_o = branch_taken_i & ~pc_o. When stalled, ID is not advancing, so branch_taken_i is ignored.
  - With branch_taken_i and haz in the same IDLE cycle, the stall wins and the flush is suppressed.
- Counter:
  - stall_cnt_o increments on each edge where pc_o=1 and rst_i=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Quiescent: with no hazard, busy or branch, all control outputs are 0 and the state stays IDLE.

Test Plan:
1. LOAD_LAT=1:
   - Stimulus: memread=1, rd=5, rs=5, uses_rs=1.
   - Response: pc_o/if_id_o/mux8_o=1 the same cycle. The next cycle, with memread=0, all 0. stall_cnt_o=1.
2. rd=0, rs=0, memread=1, uses_rs=1 -> no stall. Separately, rt match with uses_rt=0 -> no stall.
3. LOAD_LAT=3:
   - Stimulus: hazard on rt=7.
   - Response: exactly 3 consecutive cycles of pc_o=mux8_o=1, then IDLE. stall_cnt_o=3.
4. LOAD_LAT=3, mem_busy_i=1 for 2 cycles in the middle of STALL:
   - During busy: ex_hold_o=1, mux8_o=0.
   - After busy drops: bubbles resume. pc_o=1 for 5 cycles total, with 3 of those cycles having mux8_o=1.
5. branch_taken_i=1 with no hazard -> if_id_flush_o=1. branch_taken_i=1 with hazard -> if_id_flush_o=0, pc_o=1.
6. Reset and counter:
   - rst_i=1 on the 2nd cycle of a LOAD_LAT=3 stall -> outputs 0 immediately; state IDLE and stall_cnt_o=0 after the edge.
   - With CNT_W=4, 20 stall cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller pipeline-side signal bundle
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] if_idrs_i;
  logic [REG_AW-1:0] if_idrt_i;
  logic              id_uses_rs_i;
  logic              id_uses_rt_i;
  logic [REG_AW-1:0] id_ex_rd_i;
  logic              id_ex_memread_i;
  logic              branch_taken_i;
  logic              mem_busy_i;
  logic              pc_o;
  logic              if_id_o;
  logic              mux8_o;
  logic              ex_hold_o;
  logic              if_id_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output if_idrs_i, if_idrt_i, id_uses_rs_i, id_uses_rt_i,
    output id_ex_rd_i, id_ex_memread_i, branch_taken_i, mem_busy_i,
    input  pc_o, if_id_o, mux8_o, ex_hold_o, if_id_flush_o, stall_cnt_o
  );

  modport slave (
    input  if_idrs_i, if_idrt_i, id_uses_rs_i, id_uses_rt_i,
    input  id_ex_rd_i, id_ex_memread_i, branch_taken_i, mem_busy_i,
    output pc_o, if_id_o, mux8_o, ex_hold_o, if_id_flush_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use hazard controller with multi-cycle stall, freeze and flush
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);
  localparam int REM_W = 4;
  localparam logic [REG_AW-1:0] R0 = '0;

  typedef enum logic {IDLE, STALL} state_t;

  state_t             state_q;
  logic [REM_W-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;

  logic haz;
  logic busy;
  logic pc_raw;
  logic mux_raw;

  always_comb begin
    haz = bus.id_ex_memread_i && (bus.id_ex_rd_i != R0) &&
          ((bus.id_uses_rs_i && (bus.if_idrs_i == bus.id_ex_rd_i)) ||
           (bus.id_uses_rt_i && (bus.if_idrt_i == bus.id_ex_rd_i)));
  end

  // A freeze holds the front end but must not turn the held EX instruction into a bubble.
  always_comb begin
    busy    = bus.mem_busy_i;
    pc_raw  = busy || (state_q == STALL) || haz;
    mux_raw = !busy && ((state_q == STALL) || haz);
  end

  always_comb begin
    bus.pc_o          = 1'b0;
    bus.if_id_o       = 1'b0;
    bus.mux8_o        = 1'b0;
    bus.ex_hold_o     = 1'b0;
    bus.if_id_flush_o = 1'b0;
    bus.stall_cnt_o   = '0;
    if (!rst_i) begin
      bus.pc_o          = pc_raw;
      bus.if_id_o       = pc_raw;
      bus.mux8_o        = mux_raw;
      bus.ex_hold_o     = busy;
      bus.if_id_flush_o = bus.branch_taken_i && !pc_raw;
      bus.stall_cnt_o   = cnt_q;
    end
  end

  // The IDLE detection cycle is the first bubble, so STALL covers the remaining LOAD_LAT-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (pc_raw && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (!busy) begin
        case (state_q)
          IDLE: begin
            if (haz && (LOAD_LAT > 1)) begin
              state_q <= STALL;
              rem_q   <= REM_W'(LOAD_LAT - 1);
            end
          end
          STALL: begin
            if (rem_q == REM_W'(1)) begin
              state_q <= IDLE;
              rem_q   <= '0;
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            rem_q   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench over three hazard_ctrl configurations
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic [4:0] rs   = '0;
  logic [4:0] rt   = '0;
  logic [4:0] rd   = '0;
  logic       urs  = 1'b0;
  logic       urt  = 1'b0;
  logic       mr   = 1'b0;
  logic       br   = 1'b0;
  logic       busy = 1'b0;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) b0 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) b1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  b2 ();

  assign b0.if_idrs_i = rs;   assign b1.if_idrs_i = rs;   assign b2.if_idrs_i = rs;
  assign b0.if_idrt_i = rt;   assign b1.if_idrt_i = rt;   assign b2.if_idrt_i = rt;
  assign b0.id_uses_rs_i = urs; assign b1.id_uses_rs_i = urs; assign b2.id_uses_rs_i = urs;
  assign b0.id_uses_rt_i = urt; assign b1.id_uses_rt_i = urt; assign b2.id_uses_rt_i = urt;
  assign b0.id_ex_rd_i = rd;  assign b1.id_ex_rd_i = rd;  assign b2.id_ex_rd_i = rd;
  assign b0.id_ex_memread_i = mr; assign b1.id_ex_memread_i = mr; assign b2.id_ex_memread_i = mr;
  assign b0.branch_taken_i = br;  assign b1.branch_taken_i = br;  assign b2.branch_taken_i = br;
  assign b0.mem_busy_i = busy; assign b1.mem_busy_i = busy; assign b2.mem_busy_i = busy;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4))  u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  logic [2:0]       a_pc, a_ifid, a_mux, a_hold, a_flush;
  logic [2:0][15:0] a_cnt;
  assign a_pc    = {b2.pc_o, b1.pc_o, b0.pc_o};
  assign a_ifid  = {b2.if_id_o, b1.if_id_o, b0.if_id_o};
  assign a_mux   = {b2.mux8_o, b1.mux8_o, b0.mux8_o};
  assign a_hold  = {b2.ex_hold_o, b1.ex_hold_o, b0.ex_hold_o};
  assign a_flush = {b2.if_id_flush_o, b1.if_id_flush_o, b0.if_id_flush_o};
  assign a_cnt[0] = b0.stall_cnt_o;
  assign a_cnt[1] = b1.stall_cnt_o;
  assign a_cnt[2] = {12'b0, b2.stall_cnt_o};

  typedef struct packed {
    logic [2:0]       pc, ifid, mux, hold, flush;
    logic [2:0][15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: bubbles still owed after this cycle, and stall cycles seen.
  int lat  [3] = '{1, 3, 3};
  int cmax [3] = '{65535, 65535, 15};
  int left [3] = '{0, 0, 0};
  int cnt  [3] = '{0, 0, 0};

  function automatic bit model_haz(logic m, logic [4:0] d, logic [4:0] s, logic [4:0] t,
                                   logic us, logic ut);
    if (!m || d == 5'd0) return 1'b0;
    return (us && s == d) || (ut && t == d);
  endfunction

  task automatic chk(input string name, input int i, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s[dut%0d] got %0d expected %0d at %0t", name, i, act, expv, $time);
    end
  endtask

  task automatic step(input logic r, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input logic us, input logic ut,
                      input logic m, input logic b, input logic bz);
    exp_t e;
    bit   h;
    @(posedge clk);
    #1;
    rst = r; rs = s; rt = t; rd = d; urs = us; urt = ut; mr = m; br = b; busy = bz;
    e = '0;
    h = model_haz(m, d, s, t, us, ut);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        left[i] = 0;
        cnt[i]  = 0;
      end else begin
        e.cnt[i] = 16'(cnt[i]);
        if (bz) begin
          e.pc[i] = 1'b1; e.ifid[i] = 1'b1; e.hold[i] = 1'b1;
        end else if (left[i] > 0) begin
          e.pc[i] = 1'b1; e.ifid[i] = 1'b1; e.mux[i] = 1'b1;
          left[i]--;
        end else if (h) begin
          e.pc[i] = 1'b1; e.ifid[i] = 1'b1; e.mux[i] = 1'b1;
          left[i] = lat[i] - 1;
        end
        e.flush[i] = b && !e.pc[i];
        if (e.pc[i] && cnt[i] < cmax[i]) cnt[i]++;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk("pc_o",          i, int'(a_pc[i]),    int'(e.pc[i]));
          chk("if_id_o",       i, int'(a_ifid[i]),  int'(e.ifid[i]));
          chk("mux8_o",        i, int'(a_mux[i]),   int'(e.mux[i]));
          chk("ex_hold_o",     i, int'(a_hold[i]),  int'(e.hold[i]));
          chk("if_id_flush_o", i, int'(a_flush[i]), int'(e.flush[i]));
          chk("stall_cnt_o",   i, int'(a_cnt[i]),   int'(e.cnt[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 5, 5, 5, 1, 1, 1, 1, 0);
    idle(2);
    // single-cycle load-use on rs
    step(0, 5, 0, 5, 1, 0, 1, 0, 0);
    idle(3);
    // r0 never stalls; rt match without use does not stall
    step(0, 0, 0, 0, 1, 1, 1, 0, 0);
    step(0, 0, 6, 6, 0, 0, 1, 0, 0);
    idle(1);
    // rt hazard, multi-cycle stall
    step(0, 1, 7, 7, 0, 1, 1, 0, 0);
    idle(4);
    // freeze in the middle of a stall
    step(0, 1, 7, 7, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);
    // branch flush with and without hazard
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 3, 0, 3, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // reset on the second stall cycle
    step(0, 4, 0, 4, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // back-to-back hazards to saturate the narrow counter
    for (int k = 0; k < 20; k++) step(0, 2, 0, 2, 1, 0, 1, 0, 0);
    idle(2);
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 60) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
    end
    idle(2);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
